// File: rtl/ps2_command_assembler.sv
// Assembles PS/2 set-2 make codes into a packed 4-character ASCII command word.
// Break/extended sequences are swallowed; Enter hands the word over with valid/ack.
module ps2_command_assembler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ps2_key_pressed_i,
    input  logic [7:0]  ps2_key_data_i,
    input  logic        command_ack_i,
    output logic [31:0] command_o,
    output logic [2:0]  char_count_o,
    output logic        command_valid_o,
    output logic [7:0]  last_ascii_o,
    output logic        overflow_o
);

    typedef enum logic {StCollect, StReady} state_e;

    state_e      state_q;
    logic        strobe_q;
    logic        ext_q;
    logic        brk_q;
    logic [31:0] command_q;
    logic [2:0]  count_q;
    logic        valid_q;
    logic [7:0]  last_q;
    logic        overflow_q;

    logic       byte_edge;
    logic       is_prefix;
    logic       make_valid;
    logic [7:0] ascii;
    logic       is_print;
    logic       is_enter;
    logic       is_bksp;

    assign byte_edge  = ps2_key_pressed_i & ~strobe_q;
    assign is_prefix  = (ps2_key_data_i == 8'hE0) || (ps2_key_data_i == 8'hF0);
    assign make_valid = byte_edge & ~is_prefix & ~ext_q & ~brk_q;

    always_comb begin
        ascii = 8'h00;
        unique case (ps2_key_data_i)
            8'h1C: ascii = 8'h41;
            8'h32: ascii = 8'h42;
            8'h21: ascii = 8'h43;
            8'h23: ascii = 8'h44;
            8'h24: ascii = 8'h45;
            8'h2B: ascii = 8'h46;
            8'h34: ascii = 8'h47;
            8'h33: ascii = 8'h48;
            8'h43: ascii = 8'h49;
            8'h3B: ascii = 8'h4A;
            8'h42: ascii = 8'h4B;
            8'h4B: ascii = 8'h4C;
            8'h3A: ascii = 8'h4D;
            8'h31: ascii = 8'h4E;
            8'h44: ascii = 8'h4F;
            8'h4D: ascii = 8'h50;
            8'h15: ascii = 8'h51;
            8'h2D: ascii = 8'h52;
            8'h1B: ascii = 8'h53;
            8'h2C: ascii = 8'h54;
            8'h3C: ascii = 8'h55;
            8'h2A: ascii = 8'h56;
            8'h1D: ascii = 8'h57;
            8'h22: ascii = 8'h58;
            8'h35: ascii = 8'h59;
            8'h1A: ascii = 8'h5A;
            8'h45: ascii = 8'h30;
            8'h16: ascii = 8'h31;
            8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;
            8'h25: ascii = 8'h34;
            8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;
            8'h3D: ascii = 8'h37;
            8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = 8'h20;
            default: ascii = 8'h00;
        endcase
    end

    assign is_print = (ascii != 8'h00);
    assign is_enter = (ps2_key_data_i == 8'h5A);
    assign is_bksp  = (ps2_key_data_i == 8'h66);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StCollect;
            strobe_q   <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            command_q  <= 32'h0;
            count_q    <= 3'd0;
            valid_q    <= 1'b0;
            last_q     <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            strobe_q <= ps2_key_pressed_i;

            // Prefix flags track every accepted byte, whatever the FSM is doing.
            if (byte_edge) begin
                if (ps2_key_data_i == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (ps2_key_data_i == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end

            case (state_q)
                StCollect: begin
                    if (make_valid) begin
                        if (is_print) begin
                            if (count_q < 3'd4) begin
                                command_q <= {command_q[23:0], ascii};
                                count_q   <= count_q + 3'd1;
                                last_q    <= ascii;
                            end else begin
                                overflow_q <= 1'b1;
                            end
                        end else if (is_bksp && count_q != 3'd0) begin
                            command_q <= {8'h00, command_q[31:8]};
                            count_q   <= count_q - 3'd1;
                        end else if (is_enter && count_q != 3'd0) begin
                            state_q <= StReady;
                            valid_q <= 1'b1;
                        end
                    end
                end
                StReady: begin
                    // Ack wins over a simultaneous byte; the byte is simply lost.
                    if (command_ack_i) begin
                        state_q    <= StCollect;
                        command_q  <= 32'h0;
                        count_q    <= 3'd0;
                        valid_q    <= 1'b0;
                        overflow_q <= 1'b0;
                    end else if (make_valid && is_print) begin
                        overflow_q <= 1'b1;
                    end
                end
                default: state_q <= StCollect;
            endcase
        end
    end

    assign command_o       = command_q;
    assign char_count_o    = count_q;
    assign command_valid_o = valid_q;
    assign last_ascii_o    = last_q;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_ps2_command_assembler.sv
// Directed bench for ps2_command_assembler: expectations are queued as keys are
// sent and popped when the resulting outputs are sampled.
module tb_ps2_command_assembler;

    logic        clk;
    logic        rst;
    logic        pressed;
    logic [7:0]  data;
    logic        ack;
    logic [31:0] command;
    logic [2:0]  char_count;
    logic        command_valid;
    logic [7:0]  last_ascii;
    logic        overflow;

    typedef struct packed {
        logic [31:0] cmd;
        logic [2:0]  cnt;
        logic        vld;
        logic [7:0]  last;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    ps2_command_assembler dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .ps2_key_pressed_i (pressed),
        .ps2_key_data_i    (data),
        .command_ack_i     (ack),
        .command_o         (command),
        .char_count_o      (char_count),
        .command_valid_o   (command_valid),
        .last_ascii_o      (last_ascii),
        .overflow_o        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b, input int width = 1);
        @(negedge clk);
        data    = b;
        pressed = 1'b1;
        repeat (width) @(negedge clk);
        pressed = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_seq(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic expect_state(input logic [31:0] cmd, input logic [2:0] cnt, input logic vld,
                                input logic [7:0] last, input logic ovf);
        exp_t e;
        e.cmd = cmd; e.cnt = cnt; e.vld = vld; e.last = last; e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        assert (command === e.cmd) else begin
            failures++;
            $error("FAIL %s.command got=%h want=%h", tag, command, e.cmd);
        end
        checks++;
        assert (char_count === e.cnt) else begin
            failures++;
            $error("FAIL %s.char_count got=%0d want=%0d", tag, char_count, e.cnt);
        end
        checks++;
        assert (command_valid === e.vld) else begin
            failures++;
            $error("FAIL %s.command_valid got=%b want=%b", tag, command_valid, e.vld);
        end
        checks++;
        assert (last_ascii === e.last) else begin
            failures++;
            $error("FAIL %s.last_ascii got=%h want=%h", tag, last_ascii, e.last);
        end
        checks++;
        assert (overflow === e.ovf) else begin
            failures++;
            $error("FAIL %s.overflow got=%b want=%b", tag, overflow, e.ovf);
        end
    endtask

    initial begin
        rst     = 1'b1;
        pressed = 1'b0;
        data    = 8'h00;
        ack     = 1'b0;
        repeat (3) @(negedge clk);
        expect_state(32'h0, 3'd0, 1'b0, 8'h00, 1'b0);
        check("reset");
        rst = 1'b0;
        @(negedge clk);

        // "FD" with breaks, then Enter with break (break lands in READY)
        send_seq('{8'h2B, 8'hF0, 8'h2B, 8'h23, 8'hF0, 8'h23, 8'h5A, 8'hF0, 8'h5A});
        expect_state(32'h0000_4644, 3'd2, 1'b1, 8'h44, 1'b0);
        check("fd_enter");
        pulse_ack();
        expect_state(32'h0, 3'd0, 1'b0, 8'h44, 1'b0);
        check("fd_ack");

        // Backspace and Enter on an empty buffer do nothing
        send_seq('{8'h66, 8'h5A});
        expect_state(32'h0, 3'd0, 1'b0, 8'h44, 1'b0);
        check("empty_bksp_enter");

        // Long strobe yields exactly one character
        send_byte(8'h1C, 20);
        expect_state(32'h0000_0041, 3'd1, 1'b0, 8'h41, 1'b0);
        check("long_strobe");
        send_byte(8'h66);
        expect_state(32'h0, 3'd0, 1'b0, 8'h41, 1'b0);
        check("bksp_to_empty");

        // "1234" then "5" overflows, then Backspace
        send_seq('{8'h16, 8'h1E, 8'h26, 8'h25});
        expect_state(32'h3132_3334, 3'd4, 1'b0, 8'h34, 1'b0);
        check("full_1234");
        send_byte(8'h2E);
        expect_state(32'h3132_3334, 3'd4, 1'b0, 8'h34, 1'b1);
        check("overflow_5");
        send_byte(8'h66);
        expect_state(32'h0031_3233, 3'd3, 1'b0, 8'h34, 1'b1);
        check("bksp_after_ovf");
        send_byte(8'h5A);
        pulse_ack();
        expect_state(32'h0, 3'd0, 1'b0, 8'h34, 1'b0);
        check("ack_clears_ovf");

        // Printable char in READY is dropped and flags overflow
        send_seq('{8'h1C, 8'h5A, 8'h1C, 8'h66});
        expect_state(32'h0000_0041, 3'd1, 1'b1, 8'h41, 1'b1);
        check("ready_drop");
        pulse_ack();
        expect_state(32'h0, 3'd0, 1'b0, 8'h41, 1'b0);
        check("ready_ack");

        // Ack coincides with an F0 byte edge; the following 32 must be swallowed
        send_seq('{8'h32, 8'h5A});
        @(negedge clk);
        ack     = 1'b1;
        data    = 8'hF0;
        pressed = 1'b1;
        @(negedge clk);
        ack     = 1'b0;
        pressed = 1'b0;
        @(negedge clk);
        expect_state(32'h0, 3'd0, 1'b0, 8'h42, 1'b0);
        check("ack_with_byte");
        send_byte(8'h32);
        expect_state(32'h0, 3'd0, 1'b0, 8'h42, 1'b0);
        check("straddle_break");

        // Extended arrow make/break is ignored, then '1'
        send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h16});
        expect_state(32'h0000_0031, 3'd1, 1'b0, 8'h31, 1'b0);
        check("extended_skip");
        pulse_ack();
        expect_state(32'h0000_0031, 3'd1, 1'b0, 8'h31, 1'b0);
        check("ack_in_collect");

        // Async reset with 3 chars held and a pending break
        send_seq('{8'h1E, 8'h29, 8'hF0});
        expect_state(32'h0031_3220, 3'd3, 1'b0, 8'h20, 1'b0);
        check("pre_reset");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        expect_state(32'h0, 3'd0, 1'b0, 8'h00, 1'b0);
        check("async_reset");
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h1C);
        expect_state(32'h0000_0041, 3'd1, 1'b0, 8'h41, 1'b0);
        check("post_reset_a");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ps2_command_assembler.md
# ps2_command_assembler

Keystroke-to-command assembler between the PS/2 keyboard controller and the processor's command input. Consumes raw scan-code bytes with their strobe, discards break and extended sequences, and maps make codes to ASCII. Packs up to four characters into a 32-bit command word, newest character in bits [7:0], and supports backspace. On Enter it presents the word to the processor with a valid/ack handshake, replacing the free-running trigger and shift-register path.

## Interface
- No parameters; capacity fixed at 4 characters / 32 bits.
- clock  in  1  system clock (10 MHz PLL output); all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ps2_key_pressed  in  1  scan-byte strobe from PS2_Interface; level, may span several cycles
- ps2_key_data  in  8  raw scan byte, stable while ps2_key_pressed high
- command_ack  in  1  processor has consumed command; sampled only while command_valid=1
- command  out  32  packed ASCII, newest in [7:0], unused bytes 0x00
- char_count  out  3  characters held, 0..4
- command_valid  out  1  command complete, held until acked
- last_ascii  out  8  ASCII of most recent accepted character; 0x00 after reset
- overflow  out  1  sticky; a character was dropped because buffer full or command pending

## Operation
- Byte acceptance: register ps2_key_pressed each cycle; a byte is accepted on a cycle where ps2_key_pressed=1 and its registered copy=0 (rising edge). Exactly one byte per strobe, regardless of strobe width.
- Prefix tracking is independent of the state machine:
  - 0xE0 sets ext_pending.
  - 0xF0 sets brk_pending.
  - Any other byte with brk_pending or ext_pending set is discarded; both flags clear.
  - A plain byte (neither flag set) is a make code.
- Make-code mapping:
  - Letters A-Z use the standard set-2 codes (0x1C->0x41 ... 0x1A->0x5A).
  - Digits: 0x45->0x30, 0x16..0x46->0x31..0x39.
  - 0x29->0x20 (space).
  - 0x5A = Enter, 0x66 = Backspace.
  - All other codes are ignored without effect.
- States: COLLECT, READY.
- COLLECT behaviour:
  - Printable char, count<4: command <= {command[23:0], ascii}; count+1; last_ascii <= ascii.
  - Printable char, count=4: dropped; overflow <= 1.
  - Backspace, count>0: command <= {8'h00, command[31:8]}; count-1. Backspace with count=0: no effect.
  - Enter, count>0: go to READY; command_valid <= 1. Enter with count=0: ignored.
- READY behaviour:
  - command and count are frozen.
  - Printable chars are dropped and set overflow; Backspace and Enter are dropped silently.
  - command_ack=1: command <= 0, count <= 0, command_valid <= 0, overflow <= 0; return to COLLECT.
- command_ack is ignored in COLLECT.
- Reset values: command=0, char_count=0, command_valid=0, last_ascii=0x00, overflow=0, state=COLLECT, both prefix flags=0, registered strobe=0.

## Timing
- Accepted byte takes effect at the same rising edge that detects the strobe edge; outputs update one edge after ps2_key_pressed rises as seen by the clock.
- Enter -> command_valid high after the same edge; minimum valid pulse is 1 cycle.
- Ack -> command_valid low and command=0 after the edge where ack is sampled high.
- Ack and a new byte edge in the same cycle: the ack is applied and the byte is dropped; overflow stays 0 because the ack clears it.
- Prefix flags are still updated on that byte, so a release sequence straddling the ack is still swallowed.
- Reset asserted mid-operation (including in READY or with brk_pending set): all outputs go to reset values immediately, without waiting for a clock edge. The first byte after reset is treated as a plain byte.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Type "FD" as make/break pairs (2B, F0 2B, 23, F0 23), then Enter (5A, F0 5A) -> command=0x00004644, char_count=2, command_valid=1, last_ascii=0x44.
- Hold ps2_key_pressed high 20 cycles with byte 0x1C -> exactly one 'A' accepted; count=1.
- Type "1234", then "5", then Backspace (66) -> "5" sets overflow=1 with command=0x31323334 unchanged; Backspace gives command=0x00313233, count=3.
- In READY, send 0x1C; then ack -> command unchanged and overflow=1 while in READY; after ack, command=0, count=0, valid=0, overflow=0.
- E0 75 then E0 F0 75 (arrow make/break), then 0x16 -> only '1' accepted, command=0x00000031.
- Assert reset with 3 chars held and brk_pending=1 -> all outputs zero before the next clock edge; next byte 0x1C is accepted as 'A'.
